// File: rtl/cellram_arb_pkg.sv
// Shared definitions for the CellularRAM Wishbone arbiter.
//   arb_state_t : arbiter FSM states (idle, granted to m0, granted to m1)
//   GRANT_*     : one-hot grant encodings presented on grant_o ({m1,m0})
//   DEFAULT_TIMEOUT : default watchdog limit in cycles
package cellram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/cellram_wb_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter in front of the CellularRAM
// controller. Round-robin between m0 (instruction fetch) and m1 (data),
// grant held for a whole transfer, watchdog error if the slave never acks.
// Ports:
//   clk_i, rst_n_i               : clock, asynchronous active-low reset
//   mN_cyc/stb/we/sel/adr/dat_i  : master N request (N = 0, 1)
//   mN_dat_o, mN_ack_o, mN_err_o : returns to master N
//   s_cyc/stb/we/sel/adr/dat_o   : muxed request to the slave
//   s_dat_i, s_ack_i             : slave response
//   grant_o                      : one-hot current grant {m1,m0}, 00 when idle
module cellram_wb_arbiter
  import cellram_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned TW      = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      grant_o
);

  arb_state_t    r_state;
  arb_state_t    w_next;
  logic          r_last;       // 0: m0 served last, 1: m1 served last
  logic          w_last_next;
  logic [TW-1:0] r_wdog;

  logic w_req0;
  logic w_req1;
  logic w_wd_hit;
  logic w_expire;

  assign w_req0   = m0_cyc_i & m0_stb_i;
  assign w_req1   = m1_cyc_i & m1_stb_i;
  assign w_wd_hit = (r_wdog == TW'(TIMEOUT - 1));
  // An ack in the final watchdog cycle completes the transfer normally.
  assign w_expire = w_wd_hit & ~s_ack_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_wdog  <= '0;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
      // Idle always precedes a grant, so clearing here clears on grant entry.
      if (r_state == ST_IDLE) r_wdog <= '0;
      else                    r_wdog <= r_wdog + TW'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    s_cyc_o     = 1'b0;
    s_stb_o     = 1'b0;
    s_we_o      = 1'b0;
    s_sel_o     = '0;
    s_adr_o     = '0;
    s_dat_o     = '0;
    m0_dat_o    = '0;
    m0_ack_o    = 1'b0;
    m0_err_o    = 1'b0;
    m1_dat_o    = '0;
    m1_ack_o    = 1'b0;
    m1_err_o    = 1'b0;
    grant_o     = GRANT_NONE;

    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) w_next = r_last ? ST_GNT0 : ST_GNT1;
        else if (w_req0)      w_next = ST_GNT0;
        else if (w_req1)      w_next = ST_GNT1;
      end
      ST_GNT0: begin
        grant_o  = GRANT_M0;
        s_cyc_o  = m0_cyc_i & ~w_expire;
        s_stb_o  = m0_stb_i & ~w_expire;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = w_expire;
        if (s_ack_i || w_wd_hit) begin
          w_next      = ST_IDLE;
          w_last_next = 1'b0;
        end else if (!m0_cyc_i) begin
          w_next = ST_IDLE;
        end
      end
      ST_GNT1: begin
        grant_o  = GRANT_M1;
        s_cyc_o  = m1_cyc_i & ~w_expire;
        s_stb_o  = m1_stb_i & ~w_expire;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = w_expire;
        if (s_ack_i || w_wd_hit) begin
          w_next      = ST_IDLE;
          w_last_next = 1'b1;
        end else if (!m1_cyc_i) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cellram_wb_arbiter.sv
// Self-checking bench for cellram_wb_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_cellram_wb_arbiter;

  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned TW      = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc [2];
  logic        stb [2];
  logic        we  [2];
  logic [3:0]  sel [2];
  logic [31:0] adr [2];
  logic [31:0] wdat[2];
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic [31:0] m0_dat, m1_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_dat_o;
  logic [1:0]  grant;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: who owns the bus (-1 = nobody), who was served last,
  // and how many granted cycles have elapsed in the current transfer.
  int owner = -1;
  int last  = 1;
  int cnt   = 0;

  cellram_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_sel_i(sel[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(wdat[0]),
    .m0_dat_o(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_sel_i(sel[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(wdat[1]),
    .m1_dat_o(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else n_pass++;
  endtask

  // Called just after inputs change (after a negedge): compare outputs with
  // the model, advance the model past the coming rising edge, move on.
  task automatic step();
    logic        expire;
    logic [1:0]  e_grant;
    logic [6:0]  e_ctl;
    logic [31:0] e_adr, e_dat, e_d0, e_d1;
    logic [3:0]  e_ae;
    logic        r0, r1;
    #1;
    if (!rst_n) begin
      owner = -1; last = 1; cnt = 0;
    end
    expire  = (owner >= 0) && (cnt == TIMEOUT - 1) && !s_ack_i;
    e_grant = 2'b00; e_ctl = '0; e_adr = '0; e_dat = '0; e_d0 = '0; e_d1 = '0; e_ae = '0;
    if (owner >= 0) begin
      e_grant = (owner == 0) ? 2'b01 : 2'b10;
      e_ctl   = {cyc[owner] & !expire, stb[owner] & !expire, we[owner], sel[owner]};
      e_adr   = adr[owner];
      e_dat   = wdat[owner];
      if (owner == 0) begin e_d0 = s_dat_i; e_ae = {s_ack_i, expire, 2'b00}; end
      else            begin e_d1 = s_dat_i; e_ae = {2'b00, s_ack_i, expire}; end
    end
    check("grant",   grant, e_grant);
    check("s_ctl",   {s_cyc, s_stb, s_we, s_sel}, e_ctl);
    check("s_adr",   s_adr, e_adr);
    check("s_dat",   s_dat_o, e_dat);
    check("ack_err", {m0_ack, m0_err, m1_ack, m1_err}, e_ae);
    check("m0_dat",  m0_dat, e_d0);
    check("m1_dat",  m1_dat, e_d1);
    if (rst_n) begin
      if (owner < 0) begin
        r0 = cyc[0] & stb[0];
        r1 = cyc[1] & stb[1];
        cnt = 0;
        if (r0 && r1) owner = (last == 0) ? 1 : 0;
        else if (r0)  owner = 0;
        else if (r1)  owner = 1;
      end else if (s_ack_i || cnt == TIMEOUT - 1) begin
        last  = owner;
        owner = -1;
      end else if (!cyc[owner]) begin
        owner = -1;
      end else begin
        cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      sel[i] = $urandom; adr[i] = $urandom; wdat[i] = $urandom;
    end
    s_ack_i = 1'b0;
    s_dat_i = $urandom;
  endtask

  task automatic req(input int m, input logic w, input logic [3:0] s,
                     input logic [31:0] a, input logic [31:0] d);
    cyc[m] = 1'b1; stb[m] = 1'b1; we[m] = w; sel[m] = s; adr[m] = a; wdat[m] = d;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0; step(); rst_n = 1'b1;
  endtask

  initial begin
    quiet();
    // Reset state
    step(); step();
    rst_n = 1'b1;
    step();

    // m0 read of 0x100, acked in the 4th granted cycle (coincides with the
    // watchdog limit, so ack must win and no error is raised)
    req(0, 1'b0, 4'hF, 32'h100, 32'h0);
    step();
    for (int g = 0; g < 4; g++) begin
      s_ack_i = (g == 3);
      s_dat_i = (g == 3) ? 32'hDEADBEEF : $urandom;
      step();
    end
    quiet(); step();

    // Tie straight after reset: m0 first, then alternation
    reset_pulse();
    req(0, 1'b0, 4'hF, 32'h40, 32'h0);
    req(1, 1'b0, 4'hF, 32'h80, 32'h0);
    for (int i = 0; i < 12; i++) begin
      s_ack_i = (i % 3 == 2);
      s_dat_i = $urandom;
      step();
    end
    quiet(); step();

    // m1 byte-lane write
    req(1, 1'b1, 4'b0011, 32'h2000, 32'h55AA1234);
    step(); step();
    s_ack_i = 1'b1; step();
    quiet(); step();

    // Watchdog expiry, then a stray ack while idle
    req(0, 1'b0, 4'hF, 32'h300, 32'h0);
    for (int i = 0; i < 6; i++) step();
    quiet(); step();
    s_ack_i = 1'b1; step();
    quiet(); step();

    // m0 completes (last = m0), m1 aborts, next tie still goes to m1
    req(0, 1'b0, 4'hF, 32'h10, 32'h0);
    step(); s_ack_i = 1'b1; step();
    quiet(); step();
    req(1, 1'b0, 4'hF, 32'h20, 32'h0);
    step(); step();
    cyc[1] = 1'b0; step();
    step();
    req(0, 1'b0, 4'hF, 32'h30, 32'h0);
    req(1, 1'b0, 4'hF, 32'h34, 32'h0);
    step(); step();
    s_ack_i = 1'b1; step();
    quiet(); step();

    // Asynchronous reset in the middle of a transfer
    req(1, 1'b0, 4'hF, 32'h44, 32'h0);
    step(); step();
    rst_n = 1'b0; step();
    step();
    rst_n = 1'b1;
    req(0, 1'b0, 4'hF, 32'h48, 32'h0);
    req(1, 1'b0, 4'hF, 32'h4C, 32'h0);
    step(); step();
    s_ack_i = 1'b1; step();
    quiet(); step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        cyc[m]  = ($urandom_range(0, 3) != 0);
        stb[m]  = ($urandom_range(0, 3) != 0);
        we[m]   = $urandom;
        sel[m]  = $urandom;
        adr[m]  = $urandom;
        wdat[m] = $urandom;
      end
      s_ack_i = ($urandom_range(0, 9) < 3);
      s_dat_i = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
